// File: rtl/id_ex.sv
// ID->EX pipeline register: holds decoded operands and control for the execute stage.
// Optional `ID_EX_FLUSH_EN adds a flush input that squashes the stage to a bubble.
module id_ex #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ITYPE_W    = 3,
    parameter int unsigned ALUCTL_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
`ifdef ID_EX_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic [DATA_W-1:0]     d_A,
    input  logic [DATA_W-1:0]     d_B,
    input  logic [DATA_W-1:0]     d_SEimm,
    input  logic [DATA_W-1:0]     d_2hr,
    input  logic                  d_Stall,
    input  logic                  d_MemtoReg,
    input  logic                  d_RegSrc,
    input  logic                  d_MemWrite,
    input  logic                  d_MemAddrSrc,
    input  logic [ITYPE_W-1:0]    d_InstrType,
    input  logic [ALUCTL_W-1:0]   d_ALUcontrol,
    output logic [REG_ADDR_W-1:0] q_rs,
    output logic [REG_ADDR_W-1:0] q_rd,
    output logic [REG_ADDR_W-1:0] q_rt,
    output logic [DATA_W-1:0]     q_A,
    output logic [DATA_W-1:0]     q_B,
    output logic [DATA_W-1:0]     q_SEimm,
    output logic [DATA_W-1:0]     q_2hr,
    output logic                  q_Stall,
    output logic                  q_MemtoReg,
    output logic                  q_RegSrc,
    output logic                  q_MemWrite,
    output logic                  q_MemAddrSrc,
    output logic [ITYPE_W-1:0]    q_InstrType,
    output logic [ALUCTL_W-1:0]   q_ALUcontrol
);

    logic [REG_ADDR_W-1:0] r_rs, r_rd, r_rt;
    logic [DATA_W-1:0]     r_A, r_B, r_SEimm, r_2hr;
    logic                  r_Stall, r_MemtoReg, r_RegSrc, r_MemWrite, r_MemAddrSrc;
    logic [ITYPE_W-1:0]    r_InstrType;
    logic [ALUCTL_W-1:0]   r_ALUcontrol;
    logic                  w_clear;

    // All-zero contents form the NOP bubble, so reset and flush share one clear path.
`ifdef ID_EX_FLUSH_EN
    assign w_clear = reset | flush;
`else
    assign w_clear = reset;
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_rs         <= '0;
            r_rd         <= '0;
            r_rt         <= '0;
            r_A          <= '0;
            r_B          <= '0;
            r_SEimm      <= '0;
            r_2hr        <= '0;
            r_Stall      <= 1'b0;
            r_MemtoReg   <= 1'b0;
            r_RegSrc     <= 1'b0;
            r_MemWrite   <= 1'b0;
            r_MemAddrSrc <= 1'b0;
            r_InstrType  <= '0;
            r_ALUcontrol <= '0;
        end else if (en) begin
            r_rs         <= d_rs;
            r_rd         <= d_rd;
            r_rt         <= d_rt;
            r_A          <= d_A;
            r_B          <= d_B;
            r_SEimm      <= d_SEimm;
            r_2hr        <= d_2hr;
            r_Stall      <= d_Stall;
            r_MemtoReg   <= d_MemtoReg;
            r_RegSrc     <= d_RegSrc;
            r_MemWrite   <= d_MemWrite;
            r_MemAddrSrc <= d_MemAddrSrc;
            r_InstrType  <= d_InstrType;
            r_ALUcontrol <= d_ALUcontrol;
        end
    end

    assign q_rs         = r_rs;
    assign q_rd         = r_rd;
    assign q_rt         = r_rt;
    assign q_A          = r_A;
    assign q_B          = r_B;
    assign q_SEimm      = r_SEimm;
    assign q_2hr        = r_2hr;
    assign q_Stall      = r_Stall;
    assign q_MemtoReg   = r_MemtoReg;
    assign q_RegSrc     = r_RegSrc;
    assign q_MemWrite   = r_MemWrite;
    assign q_MemAddrSrc = r_MemAddrSrc;
    assign q_InstrType  = r_InstrType;
    assign q_ALUcontrol = r_ALUcontrol;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed cases plus randomized traffic against a bundle model.
module tb_id_ex;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int AW = 4;
    localparam int VW = 3 * RW + 4 * DW + 5 + IW + AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, flush;
    logic [RW-1:0] d_rs, d_rd, d_rt, q_rs, q_rd, q_rt;
    logic [DW-1:0] d_A, d_B, d_SEimm, d_2hr, q_A, q_B, q_SEimm, q_2hr;
    logic d_Stall, d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc;
    logic q_Stall, q_MemtoReg, q_RegSrc, q_MemWrite, q_MemAddrSrc;
    logic [IW-1:0] d_InstrType, q_InstrType;
    logic [AW-1:0] d_ALUcontrol, q_ALUcontrol;

    logic [VW-1:0] w_d, w_q, m_q;
    int total = 0;
    int bad = 0;

    assign w_d = {d_rs, d_rd, d_rt, d_A, d_B, d_SEimm, d_2hr, d_Stall, d_MemtoReg, d_RegSrc,
                  d_MemWrite, d_MemAddrSrc, d_InstrType, d_ALUcontrol};
    assign w_q = {q_rs, q_rd, q_rt, q_A, q_B, q_SEimm, q_2hr, q_Stall, q_MemtoReg, q_RegSrc,
                  q_MemWrite, q_MemAddrSrc, q_InstrType, q_ALUcontrol};

    id_ex #(.REG_ADDR_W(RW), .DATA_W(DW), .ITYPE_W(IW), .ALUCTL_W(AW)) u_dut (
        .clk(clk), .reset(reset), .en(en),
`ifdef ID_EX_FLUSH_EN
        .flush(flush),
`endif
        .d_rs(d_rs), .d_rd(d_rd), .d_rt(d_rt), .d_A(d_A), .d_B(d_B), .d_SEimm(d_SEimm),
        .d_2hr(d_2hr), .d_Stall(d_Stall), .d_MemtoReg(d_MemtoReg), .d_RegSrc(d_RegSrc),
        .d_MemWrite(d_MemWrite), .d_MemAddrSrc(d_MemAddrSrc), .d_InstrType(d_InstrType),
        .d_ALUcontrol(d_ALUcontrol),
        .q_rs(q_rs), .q_rd(q_rd), .q_rt(q_rt), .q_A(q_A), .q_B(q_B), .q_SEimm(q_SEimm),
        .q_2hr(q_2hr), .q_Stall(q_Stall), .q_MemtoReg(q_MemtoReg), .q_RegSrc(q_RegSrc),
        .q_MemWrite(q_MemWrite), .q_MemAddrSrc(q_MemAddrSrc), .q_InstrType(q_InstrType),
        .q_ALUcontrol(q_ALUcontrol)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_all(input int rs, input int rd, input int rt, input int a, input int b,
                           input int imm, input int hr, input logic [4:0] ctl, input int it,
                           input int alu);
        d_rs = RW'(rs); d_rd = RW'(rd); d_rt = RW'(rt);
        d_A = DW'(a); d_B = DW'(b); d_SEimm = DW'(imm); d_2hr = DW'(hr);
        {d_Stall, d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc} = ctl;
        d_InstrType = IW'(it); d_ALUcontrol = AW'(alu);
    endtask

    // Model: clear has priority, then load on enable, otherwise the bundle is kept.
    task automatic step(input string tag, input logic rst, input logic e, input logic f);
        reset = rst; en = e; flush = f;
        @(posedge clk);
        if (rst) m_q = '0;
`ifdef ID_EX_FLUSH_EN
        else if (f) m_q = '0;
`endif
        else if (e) m_q = w_d;
        #1;
        check(tag, w_q, m_q);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; flush = 1'b0; m_q = '0;
        set_all(4, 5, 6, 15, 55, 35, 65, 5'h1f, 1, 7);
        step("reset", 1'b1, 1'b1, 1'b0);
        check("reset_zero", w_q, '0);

        set_all(1, 2, 3, 10, 5, 30, 45, 5'h1f, 1, 2);
        step("load", 1'b0, 1'b1, 1'b0);
        check("load_A", q_A, 10);
        check("load_alu", q_ALUcontrol, 2);
        check("load_it", q_InstrType, 1);

        set_all(4, 5, 6, 20, 25, 230, 245, 5'h1f, 2, 0);
        step("b2b", 1'b0, 1'b1, 1'b0);
        check("b2b_rs", q_rs, 4);
        check("b2b_imm", q_SEimm, 230);

        set_all(4, 5, 6, 15, 55, 35, 65, 5'h00, 3, 0);
        repeat (3) step("hold", 1'b0, 1'b0, 1'b0);
        check("hold_A", q_A, 20);
        check("hold_B", q_B, 25);
        check("hold_2hr", q_2hr, 245);
        check("hold_stall", q_Stall, 1);
        check("hold_it", q_InstrType, 2);

        // en pulses between edges; only the sampled value matters.
        reset = 1'b0; en = 1'b1; #3; en = 1'b0;
        @(posedge clk); #1;
        check("en_glitch", w_q, m_q);
        check("en_glitch_A", q_A, 20);

        step("rst_hold", 1'b1, 1'b0, 1'b0);
        check("rst_hold_zero", w_q, '0);
        set_all(7, 8, 9, 100, 200, 300, 400, 5'h15, 5, 9);
        step("reload", 1'b0, 1'b1, 1'b0);
        check("reload_rd", q_rd, 8);
        check("reload_ctl", q_MemtoReg, 0);

`ifdef ID_EX_FLUSH_EN
        step("flush", 1'b0, 1'b0, 1'b1);
        check("flush_zero", w_q, '0);
        step("load2", 1'b0, 1'b1, 1'b0);
        step("flush_rst", 1'b1, 1'b1, 1'b1);
        check("flush_rst_zero", w_q, '0);
        step("resume", 1'b0, 1'b1, 1'b0);
        check("resume_B", q_B, 200);
`endif

        for (int i = 0; i < 400; i++) begin
            d_rs = RW'($urandom); d_rd = RW'($urandom); d_rt = RW'($urandom);
            d_A = $urandom; d_B = $urandom; d_SEimm = $urandom; d_2hr = $urandom;
            {d_Stall, d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc} = 5'($urandom);
            d_InstrType = IW'($urandom); d_ALUcontrol = AW'($urandom);
            step("rand", $urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- ID→EX pipeline register of the 5-stage pipelined processor.
- Captures decoded register indices, operand values, the immediate, the 2-halfword operand and control signals from the decode stage.
- Presents them, registered, to the execute stage.
- Supports a stall-hold via enable and a synchronous clear via reset.

Parameters:
- REG_ADDR_W, 5, width of register index fields rs/rd/rt
- DATA_W, 32, width of operand/immediate fields A/B/SEimm/2hr
- ITYPE_W, 3, width of instruction-type field
- ALUCTL_W, 4, width of ALU control field

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high clear
- en  in  1  load enable; 1 = capture inputs, 0 = hold
- d_rs, d_rd, d_rt  in  REG_ADDR_W each  source/destination register indices from decode
- d_A, d_B  in  DATA_W each  register-file read operands
- d_SEimm  in  DATA_W  sign-extended immediate
- d_2hr  in  DATA_W  second halfword/auxiliary operand
- d_Stall, d_MemtoReg, d_RegSrc, d_MemWrite, d_MemAddrSrc  in  1 each  control bits
- d_InstrType  in  ITYPE_W  instruction class
- d_ALUcontrol  in  ALUCTL_W  ALU operation select
- q_rs, q_rd, q_rt, q_A, q_B, q_SEimm, q_2hr, q_Stall, q_MemtoReg, q_RegSrc, q_MemWrite, q_MemAddrSrc, q_InstrType, q_ALUcontrol  out  same widths  registered copies of the matching d_ inputs
- Port order for positional instantiation: clk, reset, en, all d_ ports in the order above, then all q_ ports in the same order.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are driven directly from flops; no combinational path from any d_ input to any q_ output.
- At each rising clk edge, in priority order:
  - reset=1: every q_ output ← 0 (all bits), regardless of en.
  - else en=1: every q_ output ← its d_ input, latency one cycle.
  - else en=0: every q_ output holds its previous value.
- Reset values: q_rs=q_rd=q_rt=0, q_A=q_B=q_SEimm=q_2hr=0, all five control bits 0, q_InstrType=0, q_ALUcontrol=0.
- No reset fields are exempt; the all-zero state is the pipeline bubble (NOP).
- Before the first reset edge, outputs are unspecified; the integrator must assert reset at least one cycle at startup.
- Reset asserted mid-operation clears on the next edge, discarding any held contents.
- Reset with en=0 still clears.
- en toggling between edges has no effect; only its value at the edge matters.
- Fields are independent; no arithmetic, no width conversion.

Optional Feature:
- Macro: ID_EX_FLUSH_EN.
- With the macro defined:
  - Extra input port flush (1 bit), placed after en.
  - At a rising edge with reset=0 and flush=1, all q_ outputs ← 0 (bubble insertion for branch/hazard squash), regardless of en.
  - Priority: reset > flush > en.
- Without the macro: no flush port; behaviour exactly as above.

Test Plan:
- Reset clears all fields:
  - Stimulus: drive d_rs=4, d_rd=5, d_rt=6, d_A=15, d_B=55, d_SEimm=35, d_2hr=65, all control bits=1, d_InstrType=1, d_ALUcontrol=7, with reset=1, en=1, for one edge.
  - Required response: every q_ output = 0.
- Normal load:
  - Stimulus: reset=0, en=1, d_rs=1, d_rd=2, d_rt=3, d_A=10, d_B=5, d_SEimm=30, d_2hr=45, all control bits=1, d_InstrType=1, d_ALUcontrol=2, one edge.
  - Required response: q_ values equal the inputs (q_rs=1 … q_InstrType=1, q_ALUcontrol=2).
- Back-to-back update:
  - Stimulus: next edge with d_rs=4, d_rd=5, d_rt=6, d_A=20, d_B=25, d_SEimm=230, d_2hr=245, d_InstrType=2, d_ALUcontrol=0.
  - Required response: q_ reflects the new values one edge later; no stale fields.
- Hold with en=0:
  - Stimulus: after loading the step-3 values, set en=0 and change inputs to d_A=15, d_B=55, d_SEimm=35, d_2hr=65, all control bits=0, d_InstrType=3; apply several edges.
  - Required response: q_ stays at q_A=20, q_B=25, q_SEimm=230, q_2hr=245, control bits=1, q_InstrType=2.
- Reset overrides hold:
  - Stimulus: with en=0 and non-zero contents, assert reset=1 for one edge.
  - Required response: all q_ = 0. Release reset with en=1: the next edge loads the inputs.
- With ID_EX_FLUSH_EN:
  - Stimulus: flush=1, en=0, non-zero contents.
  - Required response: all q_ = 0 after one edge.
  - Stimulus: flush=1 and reset=1 together.
  - Required response: all q_ = 0.
  - Stimulus: flush=0.
  - Required response: normal load/hold resumes.
